// File: rtl/pm_page_writer.sv
// Page writer: stages up to 2**PAGE_W words in a local buffer, then streams a whole PM page
// (commit: buffered words, unloaded offsets all-ones) or fills it with all-ones (erase).
module pm_page_writer #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 13,
  parameter int PAGE_W    = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     buf_we_i,
  input  logic [PAGE_W-1:0]        buf_addr_i,
  input  logic [WORD_SIZE-1:0]     buf_data_i,
  input  logic [ADDR_W-PAGE_W-1:0] page_i,
  input  logic                     commit_i,
  input  logic                     erase_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pm_sel_o,
  output logic                     pm_we_o,
  output logic [ADDR_W-1:0]        pm_addr_o,
  output logic [WORD_SIZE-1:0]     pm_data_o
);

  localparam int DEPTH = 1 << PAGE_W;
  localparam int PN_W  = ADDR_W - PAGE_W;

  typedef enum logic [2:0] {IDLE, PRIME, WRITE, ERASE, DONE} state_t;

  state_t                state_q, state_d;
  logic [PAGE_W-1:0]     cnt_q;
  logic [PN_W-1:0]       page_q;
  logic                  is_write_q;
  logic [DEPTH-1:0]      valid_q;
  logic [WORD_SIZE-1:0]  mem [DEPTH];
  logic [WORD_SIZE-1:0]  rd_data_q;
  logic                  rd_vld_q;
  logic [PAGE_W-1:0]     rd_addr;
  logic                  load;

  assign load = buf_we_i && (state_q == IDLE);

  // Synchronous-read buffer: the read is issued one cycle ahead of the PM write that uses it.
  assign rd_addr = (state_q == PRIME) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (load)
      mem[buf_addr_i] <= buf_data_i;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (erase_i)
          state_d = ERASE;
        else if (commit_i)
          state_d = PRIME;
      end
      PRIME:        state_d = WRITE;
      WRITE, ERASE: if (cnt_q == '1) state_d = DONE;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      page_q     <= '0;
      is_write_q <= 1'b0;
      valid_q    <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      rd_vld_q <= valid_q[rd_addr];
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (erase_i || commit_i) begin
            page_q     <= page_i;
            is_write_q <= !erase_i;
          end
          if (load)
            valid_q[buf_addr_i] <= 1'b1;
        end
        WRITE, ERASE: cnt_q <= cnt_q + 1'b1;
        DONE: if (is_write_q) valid_q <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o    = (state_q != IDLE);
    pm_sel_o  = (state_q != IDLE);
    done_o    = (state_q == DONE);
    pm_we_o   = (state_q == WRITE) || (state_q == ERASE);
    pm_addr_o = {page_q, cnt_q};
    pm_data_o = '1;
    if (state_q == WRITE && rd_vld_q)
      pm_data_o = rd_data_q;
  end

endmodule

// File: tb/tb_pm_page_writer.sv
// Directed, table-driven bench for pm_page_writer (default parameters: 16-bit words, 64-word pages).
module tb_pm_page_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        buf_we;
  logic [5:0]  buf_addr;
  logic [15:0] buf_data;
  logic [6:0]  page;
  logic        commit;
  logic        erase;
  logic        busy, done, pm_sel, pm_we;
  logic [12:0] pm_addr;
  logic [15:0] pm_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [12:0] cap_a [128];
  logic [15:0] cap_d [128];

  typedef struct {
    int          ld_kind;
    logic        er;
    logic        cm;
    logic [6:0]  pg;
    int          inj;
    logic        inc;
    logic [15:0] base;
    logic        exc;
    logic [5:0]  eoff;
    logic [15:0] eval;
    int          busy;
    int          lat;
  } vec_t;

  vec_t tbl [9];

  pm_page_writer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .buf_we_i   (buf_we),
    .buf_addr_i (buf_addr),
    .buf_data_i (buf_data),
    .page_i     (page),
    .commit_i   (commit),
    .erase_i    (erase),
    .busy_o     (busy),
    .done_o     (done),
    .pm_sel_o   (pm_sel),
    .pm_we_o    (pm_we),
    .pm_addr_o  (pm_addr),
    .pm_data_o  (pm_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic load(input logic [5:0] off, input logic [15:0] d);
    buf_we = 1'b1; buf_addr = off; buf_data = d;
    @(posedge clk); #1;
    buf_we = 1'b0;
  endtask

  task automatic cmd(input logic er, input logic cm, input logic [6:0] pg);
    page = pg; erase = er; commit = cm;
    @(posedge clk); #1;
    erase = 1'b0; commit = 1'b0;
  endtask

  task automatic watch(input int inj, output int nwr, output int nbusy, output int ndone,
                       output int first_we, output int extra);
    bit seen = 0;
    nwr = 0; nbusy = 0; ndone = 0; first_we = -1; extra = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (busy) begin nbusy++; seen = 1; end
      if (done) ndone++;
      if (pm_we) begin
        if (first_we < 0) first_we = c;
        if (nwr < 128) begin cap_a[nwr] = pm_addr; cap_d[nwr] = pm_data; end
        nwr++;
      end
      if (inj != 0 && c == inj) begin
        buf_we = 1'b1; buf_addr = 6'd6; buf_data = 16'hBEEF; commit = 1'b1; erase = 1'b1;
      end
      if (inj != 0 && c == inj + 1) begin
        buf_we = 1'b0; commit = 1'b0; erase = 1'b0;
      end
      if (seen && !busy) break;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy || done || pm_we) extra++;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int nwr, nbusy, ndone, first_we, extra, aerr, derr;
    logic [12:0] ea;
    logic [15:0] ed;
    case (v.ld_kind)
      1: for (int k = 0; k < 64; k++) load(6'(k), 16'hA000 + 16'(k));
      2: load(6'd3, 16'h1234);
      3: load(6'd0, 16'h5555);
      4: load(6'd7, 16'hBEEF);
      5: begin load(6'd10, 16'h1111); load(6'd10, 16'h2222); end
      6: load(6'd5, 16'h0AAA);
      default: ;
    endcase
    cmd(v.er, v.cm, v.pg);
    watch(v.inj, nwr, nbusy, ndone, first_we, extra);
    aerr = 0; derr = 0;
    for (int i = 0; i < 64 && i < nwr; i++) begin
      ea = {v.pg, 6'(i)};
      ed = v.inc ? v.base + 16'(i) : ((v.exc && 6'(i) == v.eoff) ? v.eval : v.base);
      if (cap_a[i] !== ea) aerr++;
      if (cap_d[i] !== ed) derr++;
    end
    check($sformatf("v%0d writes", id),   nwr, 64);
    check($sformatf("v%0d addr_err", id), aerr, 0);
    check($sformatf("v%0d data_err", id), derr, 0);
    check($sformatf("v%0d done", id),     ndone, 1);
    check($sformatf("v%0d busy", id),     nbusy, v.busy);
    check($sformatf("v%0d latency", id),  first_we, v.lat);
    check($sformatf("v%0d idle_after", id), extra, 0);
  endtask

  initial begin
    int nwr, nd;
    vec_t fin;
    //          kind er cm page  inj inc base      exc off   val       busy lat
    tbl[0] = '{1, 0, 1, 7'd5,   0, 1, 16'hA000, 0, 6'd0,  16'h0000, 66, 2};
    tbl[1] = '{2, 0, 1, 7'd0,   0, 0, 16'hFFFF, 1, 6'd3,  16'h1234, 66, 2};
    tbl[2] = '{0, 0, 1, 7'd0,   0, 0, 16'hFFFF, 0, 6'd0,  16'h0000, 66, 2};
    tbl[3] = '{3, 1, 0, 7'd127, 0, 0, 16'hFFFF, 0, 6'd0,  16'h0000, 65, 1};
    tbl[4] = '{0, 0, 1, 7'd127, 0, 0, 16'hFFFF, 1, 6'd0,  16'h5555, 66, 2};
    tbl[5] = '{4, 1, 1, 7'd2,   0, 0, 16'hFFFF, 0, 6'd0,  16'h0000, 65, 1};
    tbl[6] = '{0, 0, 1, 7'd2,   0, 0, 16'hFFFF, 1, 6'd7,  16'hBEEF, 66, 2};
    tbl[7] = '{5, 0, 1, 7'd1,   0, 0, 16'hFFFF, 1, 6'd10, 16'h2222, 66, 2};
    tbl[8] = '{6, 0, 1, 7'd3,   4, 0, 16'hFFFF, 1, 6'd5,  16'h0AAA, 66, 2};

    rst = 1'b1; buf_we = 1'b0; buf_addr = '0; buf_data = '0; page = '0; commit = 1'b0; erase = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy",   int'(busy),   0);
    check("rst done",   int'(done),   0);
    check("rst pm_sel", int'(pm_sel), 0);
    check("rst pm_we",  int'(pm_we),  0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Reset during the 10th write cycle aborts the command silently.
    load(6'd1, 16'h7777);
    cmd(1'b0, 1'b1, 7'd4);
    nwr = 0; nd = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (pm_we) nwr++;
      if (done) nd++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort pm_we", int'(pm_we), 0);
    check("abort busy",  int'(busy),  0);
    check("abort done",  int'(done),  0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nwr += 100;
    end
    check("abort writes", nwr, 10);
    check("abort no_done", nd, 0);
    @(posedge clk); #1;
    fin = '{0, 0, 1, 7'd4, 0, 0, 16'hFFFF, 0, 6'd0, 16'h0000, 66, 2};
    run_vec(fin, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pm_page_writer.md
PM_PAGE_WRITER -- requirements
Module: pm_page_writer

Interface
REQ-001 Parameter WORD_SIZE, default 16, PM word width in bits.
REQ-002 Parameter ADDR_W, default 13, PM word-address width.
REQ-003 Parameter PAGE_W, default 6, page-offset width; page holds 2**PAGE_W words; PAGE_W < ADDR_W.
REQ-004 Port clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst_i  in  1  reset, synchronous, active-high.
REQ-006 Port buf_we_i  in  1  load one word into the page buffer.
REQ-007 Port buf_addr_i  in  PAGE_W  page-buffer word offset.
REQ-008 Port buf_data_i  in  WORD_SIZE  word to load.
REQ-009 Port page_i  in  ADDR_W-PAGE_W  target page number.
REQ-010 Port commit_i  in  1  request: write the buffer to page page_i.
REQ-011 Port erase_i  in  1  request: fill page page_i with all-ones.
REQ-012 Port busy_o  out  1  high while a command is in progress.
REQ-013 Port done_o  out  1  one-cycle pulse at command completion.
REQ-014 Port pm_sel_o  out  1  high while this block owns the PM write port.
REQ-015 Port pm_we_o  out  1  PM write enable.
REQ-016 Port pm_addr_o  out  ADDR_W  PM word address.
REQ-017 Port pm_data_o  out  WORD_SIZE  PM write data.

Function
REQ-018 Internal page buffer SHALL hold 2**PAGE_W words with synchronous read, plus one valid bit per word.
REQ-019 In IDLE, buf_we_i=1 SHALL write buf_data_i at buf_addr_i and set its valid bit; a rewrite of the same offset keeps the last value.
REQ-020 buf_we_i SHALL be ignored in every state other than IDLE.
REQ-021 FSM states SHALL be IDLE, PRIME, WRITE, ERASE, DONE.
REQ-022 Commands SHALL be accepted only in IDLE; page_i SHALL be latched at acceptance.
REQ-023 IDLE with erase_i=1 -> ERASE; otherwise, IDLE with commit_i=1 -> PRIME. Erase wins when both are high.
REQ-024 PRIME SHALL last 1 cycle, issue the buffer read of offset 0 and assert no pm_we_o, then go to WRITE.
REQ-025 WRITE SHALL last 2**PAGE_W cycles; in the cycle for offset k it SHALL drive pm_we_o=1 and pm_addr_o={page,k}.
REQ-026 In WRITE, pm_data_o SHALL be buffer[k] when valid[k]=1, else all-ones; offsets are issued in ascending order 0..2**PAGE_W-1.
REQ-027 ERASE SHALL last 2**PAGE_W cycles with pm_we_o=1, pm_addr_o={page,k} for k ascending and pm_data_o all-ones; the buffer is not modified.
REQ-028 The offset counter is PAGE_W bits; the terminal count 2**PAGE_W-1 SHALL end the phase and go to DONE, with no wrap into a further write.
REQ-029 DONE SHALL last 1 cycle with done_o=1 and pm_we_o=0, then go to IDLE.
REQ-030 DONE following WRITE SHALL clear all valid bits; DONE following ERASE SHALL leave them unchanged.
REQ-031 busy_o and pm_sel_o SHALL be 1 in PRIME, WRITE, ERASE and DONE, and 0 in IDLE.
REQ-032 Outside WRITE/ERASE, pm_we_o SHALL be 0; pm_addr_o and pm_data_o are don't-care while pm_we_o=0.
REQ-033 Commit latency: accept edge -> busy_o=1 the next cycle -> first pm_we_o 2 cycles after accept; busy spans 2**PAGE_W+2 cycles (write) or 2**PAGE_W+1 cycles (erase).

Reset
REQ-034 rst_i=1 SHALL force IDLE, clear all valid bits and the offset counter, and drive busy_o, done_o, pm_sel_o and pm_we_o to 0 from the next edge.
REQ-035 Reset mid-command SHALL abort it with no done_o pulse; PM words already written remain written.
REQ-036 Buffer data storage need not be reset.

Verification (WORD_SIZE=16, ADDR_W=13, PAGE_W=6)
REQ-037 Load offsets 0..63 with 0xA000+k, commit page 5 -> 64 consecutive writes to 0x140..0x17F with data 0xA000..0xA03F, done_o a single pulse, busy_o high for 66 cycles.
REQ-038 Load only offset 3=0x1234, commit page 0 -> address 0x003 gets 0x1234 and the other 63 addresses get 0xFFFF; an immediate second commit writes 0xFFFF everywhere (buffer cleared).
REQ-039 Load offset 0=0x5555, erase page 127 -> 64 writes of 0xFFFF to 0x1FC0..0x1FFF; a following commit page 127 writes 0x5555 to 0x1FC0.
REQ-040 erase_i=1 and commit_i=1 in the same IDLE cycle -> erase sequence only, exactly 64 writes of 0xFFFF, one done_o.
REQ-041 buf_we_i, commit_i and erase_i pulsed during a busy write -> ignored; buffer contents and the write count are unchanged.
REQ-042 rst_i on the 10th WRITE cycle -> pm_we_o=0 and busy_o=0 on the next cycle, no done_o pulse, and a later commit without loads writes all 0xFFFF.
